// File: rtl/nasti_stream_arbiter_if.sv
// NASTI-stream arbiter bus bundle: N_PORT packed input streams plus one
// output stream. The master modport is the environment side (sources feeding
// the inputs and the sink consuming the output). The slave modport is the
// arbiter side.
interface nasti_stream_arbiter_if #(
  parameter int N_PORT     = 8,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic [N_PORT-1:0]                     s_valid;
  logic [N_PORT-1:0]                     s_ready;
  logic [N_PORT-1:0][DATA_WIDTH-1:0]     s_data;
  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]   s_strb;
  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]   s_keep;
  logic [N_PORT-1:0]                     s_last;
  logic [N_PORT-1:0][ID_WIDTH-1:0]       s_id;
  logic [N_PORT-1:0][DEST_WIDTH-1:0]     s_dest;
  logic [N_PORT-1:0][USER_WIDTH-1:0]     s_user;

  logic                                  m_valid;
  logic                                  m_ready;
  logic [DATA_WIDTH-1:0]                 m_data;
  logic [DATA_WIDTH/8-1:0]               m_strb;
  logic [DATA_WIDTH/8-1:0]               m_keep;
  logic                                  m_last;
  logic [ID_WIDTH-1:0]                   m_id;
  logic [DEST_WIDTH-1:0]                 m_dest;
  logic [USER_WIDTH-1:0]                 m_user;

  modport master (
    output s_valid, s_data, s_strb, s_keep, s_last, s_id, s_dest, s_user, m_ready,
    input  s_ready, m_valid, m_data, m_strb, m_keep, m_last, m_id, m_dest, m_user
  );

  modport slave (
    input  s_valid, s_data, s_strb, s_keep, s_last, s_id, s_dest, s_user, m_ready,
    output s_ready, m_valid, m_data, m_strb, m_keep, m_last, m_id, m_dest, m_user
  );
endinterface

// File: rtl/nasti_stream_arbiter.sv
// Packet-granular round-robin arbiter for one NASTI-stream crossbar output.
// A grant is issued from IDLE (one bubble per packet) and is held until the
// t_last beat is accepted. After that, rr_ptr moves to the finished port.
// Optional macro NASTI_STREAM_ARB_STALL_DET_EN adds a mid-packet idle counter
// and a sticky stall_err output.

// Per-lane request qualification and ready steering.
module nasti_stream_arb_lane #(
  parameter int DEST_WIDTH = 1,
  parameter int DEST_ID    = 0
) (
  input  logic                  s_valid,
  input  logic [DEST_WIDTH-1:0] s_dest,
  input  logic                  granted,
  input  logic                  busy,
  input  logic                  m_ready,
  output logic                  req,
  output logic                  s_ready
);
  assign req     = s_valid && (s_dest == DEST_WIDTH'(DEST_ID));
  assign s_ready = busy && granted && m_ready;
endmodule

module nasti_stream_arbiter #(
  parameter  int N_PORT      = 8,
  parameter  int DATA_WIDTH  = 64,
  parameter  int ID_WIDTH    = 1,
  parameter  int DEST_WIDTH  = 1,
  parameter  int USER_WIDTH  = 1,
  parameter  int DEST_ID     = 0,
  parameter  int STALL_LIMIT = 255,
  localparam int IDX_W       = $clog2(N_PORT)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  nasti_stream_arbiter_if.slave bus,
  output logic [IDX_W-1:0]     grant_idx,
`ifdef NASTI_STREAM_ARB_STALL_DET_EN
  output logic                 stall_err,
`endif
  output logic                 busy
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    pick;
  logic                found;
  logic [N_PORT-1:0]   req;
  logic                g_valid;
  logic                xfer;

  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_q;
  assign g_valid   = bus.s_valid[grant_q];
  assign xfer      = busy && g_valid && bus.m_ready;

  for (genvar i = 0; i < N_PORT; i++) begin : g_lane
    nasti_stream_arb_lane #(
      .DEST_WIDTH(DEST_WIDTH),
      .DEST_ID   (DEST_ID)
    ) u_lane (
      .s_valid(bus.s_valid[i]),
      .s_dest (bus.s_dest[i]),
      .granted(grant_q == IDX_W'(i)),
      .busy   (busy),
      .m_ready(bus.m_ready),
      .req    (req[i]),
      .s_ready(bus.s_ready[i])
    );
  end

  // Output is a straight copy of the granted lane. m_valid depends only on
  // state and s_valid, never on m_ready.
  assign bus.m_valid = busy && g_valid;
  assign bus.m_data  = bus.s_data[grant_q];
  assign bus.m_strb  = bus.s_strb[grant_q];
  assign bus.m_keep  = bus.s_keep[grant_q];
  assign bus.m_last  = bus.s_last[grant_q];
  assign bus.m_id    = bus.s_id[grant_q];
  assign bus.m_dest  = bus.s_dest[grant_q];
  assign bus.m_user  = bus.s_user[grant_q];

  // Round-robin search: first request after rr_ptr, wrapping modulo N_PORT.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    for (int k = 1; k <= N_PORT; k++) begin
      if (!found && req[(int'(rr_q) + k) % N_PORT]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(rr_q) + k) % N_PORT);
      end
    end
  end

  // Next-state: grant from IDLE, release on an accepted t_last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
        end
      end
      BUSY: begin
        if (xfer && bus.s_last[grant_q]) begin
          state_d = IDLE;
          rr_d    = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset gives port 0 first priority.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IDX_W'(N_PORT - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

`ifdef NASTI_STREAM_ARB_STALL_DET_EN
  localparam int CW = ($clog2(STALL_LIMIT + 1) > 8) ? $clog2(STALL_LIMIT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          stall_cyc;
  logic          stall_hit;

  // Count consecutive idle cycles of the granted source. The error is
  // flagged in the cycle that reaches the limit.
  always_comb begin
    stall_cyc = busy && !g_valid;
    stall_hit = stall_cyc && ((int'(cnt_q) + 1) >= STALL_LIMIT);
    cnt_d     = '0;
    if (stall_cyc) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    err_d     = err_q | stall_hit;
  end

  // Stall counter and sticky error flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stall_err = err_q | stall_hit;
`endif
endmodule

// File: tb/tb_nasti_stream_arbiter.sv
// Bench for nasti_stream_arbiter. It uses per-port source queues and an
// expected-beat scoreboard, a cycle table for the first two-port scenario,
// and hand sequences for the other corner cases.
module tb_nasti_stream_arbiter;
  localparam int NP = 8;
  localparam int DW = 64;

  logic aclk = 1'b0;
  logic aresetn;
  logic [2:0] grant_idx;
  logic busy;
`ifdef NASTI_STREAM_ARB_STALL_DET_EN
  logic stall_err;
`endif

  always #5 aclk = ~aclk;

  nasti_stream_arbiter_if #(.N_PORT(NP), .DATA_WIDTH(DW)) bus ();

  nasti_stream_arbiter #(.N_PORT(NP), .DATA_WIDTH(DW), .DEST_ID(0), .STALL_LIMIT(10)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .bus      (bus),
    .grant_idx(grant_idx),
`ifdef NASTI_STREAM_ARB_STALL_DET_EN
    .stall_err(stall_err),
`endif
    .busy     (busy)
  );

  typedef struct { logic [DW-1:0] data; logic last; logic dest; } beat_t;
  typedef struct { int port; logic [DW-1:0] data; logic last; } exp_t;
  typedef struct {
    logic       m_ready;
    logic       m_valid;
    logic       m_last;
    logic [2:0] grant;
    logic       busy;
    logic [7:0] s_ready;
  } row_t;

  beat_t src_q[NP][$];
  exp_t  exp_q[$];
  logic [NP-1:0] hold;
  int checks = 0, failures = 0;
  int cyc = 0, last_x = -1, pkt_id = 0;
  bit gap_chk = 0, mr_toggle = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_pkt(input int port, input int nbeats, input logic dest);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < nbeats; k++) begin
      b.data = {16'(16'hA000 + port), 16'(pkt_id), 32'(k)};
      b.last = (k == nbeats - 1);
      b.dest = dest;
      src_q[port].push_back(b);
      if (dest == 1'b0) begin
        e.port = port; e.data = b.data; e.last = b.last;
        exp_q.push_back(e);
      end
    end
    pkt_id++;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        bus.s_valid[i] = 1'b1;
        bus.s_data[i]  = src_q[i][0].data;
        bus.s_last[i]  = src_q[i][0].last;
        bus.s_dest[i]  = src_q[i][0].dest;
      end else begin
        bus.s_valid[i] = 1'b0;
        bus.s_data[i]  = '0;
        bus.s_last[i]  = 1'b0;
        bus.s_dest[i]  = 1'b0;
      end
      bus.s_strb[i] = '1;
      bus.s_keep[i] = '1;
      bus.s_id[i]   = 1'(i);
      bus.s_user[i] = 1'b0;
    end
    bus.m_ready = mr_toggle ? ~cyc[0] : 1'b1;
  endtask

  // Called mid-cycle with inputs stable: scoreboard the output beat and
  // retire accepted source beats.
  task automatic sample();
    exp_t e;
    logic ok;
    cyc++;
    ok = 1'b1;
    for (int i = 0; i < NP; i++)
      if (bus.s_ready[i] && !(busy && bus.m_ready && grant_idx == 3'(i))) ok = 1'b0;
    if (bus.m_valid && !busy) ok = 1'b0;
    chk("ready_steer", {63'd0, ok}, 64'd1);
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", bus.m_data, '0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_port", 64'(grant_idx), 64'(e.port));
        chk("beat_data", bus.m_data, e.data);
        chk("beat_last", 64'(bus.m_last), 64'(e.last));
      end
      if (gap_chk && last_x >= 0) chk("rr_gap", 64'(cyc - last_x), 64'd2);
      last_x = cyc;
    end
    for (int i = 0; i < NP; i++)
      if (bus.s_valid[i] && bus.s_ready[i]) void'(src_q[i].pop_front());
  endtask

  task automatic tick();
    #2;
    sample();
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic run(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    hold = '0; mr_toggle = 0; gap_chk = 0; last_x = -1;
    drive();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  row_t tbl[7];

  initial begin
    aresetn = 1'b0;
    hold = '0;
    tbl[0] = '{1, 0, 0, 0, 0, 8'h00};
    tbl[1] = '{1, 1, 0, 0, 1, 8'h01};
    tbl[2] = '{1, 1, 1, 0, 1, 8'h01};
    tbl[3] = '{1, 0, 0, 0, 0, 8'h00};
    tbl[4] = '{1, 1, 0, 3, 1, 8'h08};
    tbl[5] = '{1, 1, 1, 3, 1, 8'h08};
    tbl[6] = '{1, 0, 0, 3, 0, 8'h00};

    // Ports 0 and 3 with 2-beat packets, stepped against the cycle table.
    do_reset();
    load_pkt(0, 2, 1'b0);
    load_pkt(3, 2, 1'b0);
    drive();
    for (int k = 0; k < 7; k++) begin
      bus.m_ready = tbl[k].m_ready;
      #1;
      chk($sformatf("t1_m_valid[%0d]", k), 64'(bus.m_valid), 64'(tbl[k].m_valid));
      chk($sformatf("t1_m_last[%0d]", k), 64'(bus.m_valid & bus.m_last), 64'(tbl[k].m_last));
      chk($sformatf("t1_grant[%0d]", k), 64'(grant_idx), 64'(tbl[k].grant));
      chk($sformatf("t1_busy[%0d]", k), 64'(busy), 64'(tbl[k].busy));
      chk($sformatf("t1_s_ready[%0d]", k), 64'(bus.s_ready), 64'(tbl[k].s_ready));
      tick();
    end
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // Ports 1, 2, 5 with single-beat packets: fair order, one beat every 2 cycles.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      load_pkt(1, 1, 1'b0);
      load_pkt(2, 1, 1'b0);
      load_pkt(5, 1, 1'b0);
    end
    gap_chk = 1;
    drive();
    run("t2", 40);
    gap_chk = 0;

    // Port 4 4-beat packet under m_ready toggling, port 6 waiting behind it.
    do_reset();
    mr_toggle = 1;
    load_pkt(4, 4, 1'b0);
    load_pkt(6, 2, 1'b0);
    drive();
    run("t3", 60);
    mr_toggle = 0;

    // Port 2 with foreign dest is never granted, even ahead of port 3 in rr order.
    do_reset();
    load_pkt(2, 1, 1'b1);
    drive();
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t4_m_valid", 64'(bus.m_valid), 64'd0);
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_s_ready2", 64'(bus.s_ready[2]), 64'd0);
      tick();
    end
    load_pkt(3, 1, 1'b0);
    drive();
    run("t4", 20);
    chk("t4_port2_untaken", 64'(src_q[2].size()), 64'd1);

    // Asynchronous reset during beat 2 of 4; port 0 leads afterwards.
    do_reset();
    load_pkt(5, 4, 1'b0);
    drive();
    for (int n = 0; n < 20 && exp_q.size() > 2; n++) tick();
    chk("t5_pre_busy", 64'(busy), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t5_m_valid", 64'(bus.m_valid), 64'd0);
    chk("t5_s_ready", 64'(bus.s_ready), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_grant", 64'(grant_idx), 64'd0);
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    load_pkt(0, 1, 1'b0);
    load_pkt(5, 1, 1'b0);
    drive();
    run("t5", 20);

`ifdef NASTI_STREAM_ARB_STALL_DET_EN
    // Granted port idles 10 cycles mid-packet; flag rises in the 10th and sticks.
    do_reset();
    load_pkt(1, 3, 1'b0);
    drive();
    for (int n = 0; n < 20 && exp_q.size() > 2; n++) tick();
    hold[1] = 1'b1;
    drive();
    for (int j = 1; j <= 10; j++) begin
      #1;
      chk($sformatf("t6_stall_err[%0d]", j), 64'(stall_err), 64'(j == 10));
      tick();
    end
    hold[1] = 1'b0;
    drive();
    run("t6", 20);
    #1;
    chk("t6_sticky", 64'(stall_err), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
